fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port imem_req, output, 1, instruction-memory request.
REQ-006 The block SHALL have port imem_addr, output, 32, request address, word aligned.
REQ-007 The block SHALL have port imem_gnt, input, 1, request accepted this cycle.
REQ-008 The block SHALL have ports imem_rvalid, input, 1, and imem_rdata, input, 32, for in-order read responses.
REQ-009 The block SHALL have ports redirect_valid, input, 1, and redirect_pc, input, 32, for branch/jump target; bits [1:0] are ignored.
REQ-010 The block SHALL have port halt, input, 1, which stops issue of new requests.
REQ-011 The block SHALL have ports inst_valid, output, 1; inst_ready, input, 1; inst_code, output, 32; and inst_pc, output, 32, forming the decode-side handshake.
REQ-012 The block SHALL have port halted, output, 1, high when in HALT with nothing in flight.

Function
REQ-013 The FSM SHALL have states BOOT, RUN and HALT; reset enters BOOT; BOOT -> RUN after exactly one clock; RUN -> HALT when halt=1; HALT -> RUN when halt=0.
REQ-014 The fetch pointer pc SHALL hold the next address to request; imem_addr SHALL equal {pc[31:2],2'b00}.
REQ-015 imem_req SHALL be high only in RUN, with no redirect_valid this cycle, and outstanding + buffer occupancy < 2.
REQ-016 On imem_req && imem_gnt, pc SHALL advance by 4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0), and outstanding SHALL increment.
REQ-017 While imem_req=1 and imem_gnt=0, imem_addr SHALL remain stable unless a redirect occurs.
REQ-018 Each imem_rvalid SHALL decrement outstanding; the response SHALL be written to a 2-entry in-order buffer along with its fetch address, unless the drop count is nonzero.
REQ-019 The credit rule in REQ-015 SHALL guarantee the buffer never overflows; a write to a full buffer is an error and SHALL never occur.
REQ-020 inst_valid SHALL be high when the buffer is non-empty; inst_code and inst_pc SHALL show the head entry; the head SHALL be popped on inst_valid && inst_ready.
REQ-021 Buffer write and pop in the same cycle SHALL both take effect; a response arriving when the buffer is empty SHALL appear on inst_valid the next cycle (1-cycle latency).
REQ-022 On redirect_valid: pc <= {redirect_pc[31:2],2'b00}; buffer flushed; drop count <= outstanding after this cycle's gnt/rvalid; first new request issued the following cycle if in RUN.
REQ-023 A response arriving while drop count > 0 SHALL be discarded and decrement drop count, including a response arriving in the redirect cycle itself.
REQ-024 A pop coinciding with a redirect SHALL count as accepted; the buffer SHALL be empty afterwards.
REQ-025 Redirect SHALL be honoured in BOOT, RUN and HALT; in HALT only pc, flush and drop are updated, with no request.
REQ-026 In HALT, in-flight responses SHALL complete and the buffer SHALL drain normally.
REQ-027 halted SHALL be high in HALT when outstanding = 0.

Reset
REQ-028 While reset=0, the block SHALL hold: state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_code=0, inst_pc=0, buffer empty, outstanding=0, drop count=0, halted=0.
REQ-029 Reset asserted mid-operation SHALL abandon all in-flight requests; responses arriving after reset release SHALL NOT be expected by the bench.
REQ-030 Reset release SHALL be synchronised by the integrator; the block SHALL need no internal synchronizer.

Verification
REQ-031 Reset release, gnt tied 1, 1-cycle rvalid, ready tied 1 -> addr 0,4,8,... on consecutive cycles; inst_pc trails by 2 cycles; first request in cycle 2.
REQ-032 inst_ready=0 with two responses buffered -> imem_req stays 0; one pop -> exactly one new request.
REQ-033 Redirect to 32'h100 with 2 requests outstanding -> both responses dropped; next inst_pc=32'h100, then 32'h104.
REQ-034 RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 halt=1 mid-stream -> no new req; buffer drains; halted=1 once outstanding=0; halt=0 -> resumes at next sequential pc.
REQ-036 Redirect, rvalid and pop in the same cycle -> pop accepted, response dropped, buffer empty next cycle.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch front-end: issues word-aligned sequential fetches under a
// two-slot credit limit, buffers in-order responses with their fetch address
// in a 2-entry queue, and handles redirects by flushing and dropping stale
// responses that are still in flight.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc,
  output logic        halted
);

  // state   | meaning
  // ST_BOOT | first cycle after reset, no requests issued
  // ST_RUN  | issuing sequential fetches while credit allows
  // ST_HALT | no new requests; in-flight responses complete, buffer drains
  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] resp_pc_q;      // fetch address of the next kept response
  logic [1:0]  outstanding_q, outstanding_d;
  logic [1:0]  drop_q;
  logic [1:0]  count_q;
  logic        rd_ptr_q, wr_ptr_q;
  logic [31:0] buf_code_q [2];
  logic [31:0] buf_pc_q   [2];

  logic        pop, push, fire;
  logic [2:0]  in_use;
  logic [31:0] redirect_base;
  logic        unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_base        = {redirect_pc[31:2], 2'b00};

  assign inst_valid = (count_q != 2'd0);
  assign pop        = inst_valid && inst_ready;
  assign inst_code  = inst_valid ? buf_code_q[rd_ptr_q] : 32'h0;
  assign inst_pc    = inst_valid ? buf_pc_q[rd_ptr_q]   : 32'h0;

  // A pop this cycle frees its slot immediately, so a steady stream with
  // single-cycle memory latency can keep one request per cycle in flight.
  assign in_use    = {1'b0, outstanding_q} + {1'b0, count_q} - {2'b00, pop};
  assign imem_req  = (state_q == ST_RUN) && !redirect_valid && (in_use < 3'd2);
  assign imem_addr = {pc_q[31:2], 2'b00};
  assign fire      = imem_req && imem_gnt;

  // Responses are kept only when no stale responses remain to be dropped;
  // anything arriving in a redirect cycle belongs to the old stream.
  assign push = imem_rvalid && (drop_q == 2'd0) && !redirect_valid;

  assign outstanding_d = outstanding_q + {1'b0, fire} - {1'b0, imem_rvalid};
  assign halted        = (state_q == ST_HALT) && (outstanding_q == 2'd0);

  // Next-state logic for the boot/run/halt sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (halt)  state_d = ST_HALT;
      ST_HALT: if (!halt) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // Fetch pointer, credit/drop counters and buffer pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_q        <= 2'd0;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      if (redirect_valid) begin
        pc_q      <= redirect_base;
        resp_pc_q <= redirect_base;
        drop_q    <= outstanding_d;
        count_q   <= 2'd0;
        rd_ptr_q  <= wr_ptr_q;
      end else begin
        if (fire) pc_q <= pc_q + 32'd4;
        if (push) begin
          resp_pc_q <= resp_pc_q + 32'd4;
          wr_ptr_q  <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
        if (imem_rvalid && (drop_q != 2'd0)) drop_q <= drop_q - 2'd1;
        count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // Response buffer storage: instruction word plus its fetch address.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_code_q[0] <= 32'h0;
      buf_code_q[1] <= 32'h0;
      buf_pc_q[0]   <= 32'h0;
      buf_pc_q[1]   <= 32'h0;
    end else if (push) begin
      buf_code_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then a
// long randomized run, all checked every cycle against a queue-based model.
module tb_fetch_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid, halt, inst_valid, inst_ready, halted;
  logic [31:0] redirect_pc, inst_code, inst_pc;

  logic        hi_req;
  logic [31:0] hi_addr;
  logic        unused_hi_valid, unused_hi_halted;
  logic [31:0] unused_hi_code, unused_hi_pc;

  always #5 clock = ~clock;

  fetch_ctrl u_dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_code(inst_code), .inst_pc(inst_pc), .halted(halted)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .clock(clock), .reset(reset),
    .imem_req(hi_req), .imem_addr(hi_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .inst_valid(unused_hi_valid), .inst_ready(inst_ready),
    .inst_code(unused_hi_code), .inst_pc(unused_hi_pc), .halted(unused_hi_halted)
  );

  typedef struct {
    logic [31:0] addr;
    int          stamp;
  } mreq_t;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // model state
  mreq_t       mem_q[$];
  logic [31:0] m_buf[$];
  logic [31:0] m_pc;
  int          m_mode, m_out, m_drop;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory environment: grant and in-order responses with >= 1 cycle latency.
  task automatic drive_env(input int gp, input int rp);
    imem_gnt = (int'($urandom_range(99)) < gp);
    if (reset && mem_q.size() > 0 && mem_q[0].stamp < cyc &&
        int'($urandom_range(99)) < rp) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  task automatic cycle(input bit rst, input bit rdy, input bit rdr,
                       input logic [31:0] rpc, input bit hlt, input int gp, input int rp);
    @(negedge clock);
    reset          = rst;
    inst_ready     = rdy;
    redirect_valid = rdr;
    redirect_pc    = rpc;
    halt           = hlt;
    drive_env(gp, rp);
    #4;
  endtask

  // Compare process: every cycle, check outputs against the model, then
  // advance the model with this cycle's inputs.
  always begin : compare
    bit          m_pop, e_req, take, fire;
    logic [31:0] raddr;
    mreq_t       r;
    @(negedge clock);
    #3;
    if (!reset) begin
      m_mode = M_BOOT; m_pc = 32'h0; m_out = 0; m_drop = 0;
      m_buf.delete();
      mem_q.delete();
      chk("rst_req",    32'(imem_req),   32'd0);
      chk("rst_addr",   imem_addr,       32'h0);
      chk("rst_valid",  32'(inst_valid), 32'd0);
      chk("rst_code",   inst_code,       32'h0);
      chk("rst_pc",     inst_pc,         32'h0);
      chk("rst_halted", 32'(halted),     32'd0);
    end else begin
      m_pop = (m_buf.size() > 0) && inst_ready;
      e_req = (m_mode == M_RUN) && !redirect_valid &&
              (m_out + m_buf.size() - int'(m_pop) < 2);
      chk("req",    32'(imem_req),   32'(e_req));
      chk("addr",   imem_addr,       m_pc);
      chk("valid",  32'(inst_valid), 32'(m_buf.size() > 0));
      chk("halted", 32'(halted),     32'((m_mode == M_HALT) && (m_out == 0)));
      if (m_buf.size() > 0) begin
        chk("inst_pc",   inst_pc,   m_buf[0]);
        chk("inst_code", inst_code, mem_word(m_buf[0]));
      end
      take  = 1'b0;
      raddr = 32'h0;
      fire  = e_req && imem_gnt;
      if (imem_rvalid && mem_q.size() > 0) begin
        r     = mem_q.pop_front();
        raddr = r.addr;
        m_out--;
        if (redirect_valid)  take = 1'b0;
        else if (m_drop > 0) m_drop--;
        else                 take = 1'b1;
      end
      if (m_pop) void'(m_buf.pop_front());
      if (take)  m_buf.push_back(raddr);
      if (fire) begin
        mem_q.push_back('{addr: m_pc, stamp: cyc});
        m_pc = m_pc + 32'd4;
        m_out++;
      end
      if (redirect_valid) begin
        m_buf.delete();
        m_pc   = {redirect_pc[31:2], 2'b00};
        m_drop = m_out;
      end
      chk("buf_bound", 32'(m_buf.size() <= 2), 32'd1);
      case (m_mode)
        M_BOOT:  m_mode = M_RUN;
        M_RUN:   if (halt)  m_mode = M_HALT;
        default: if (!halt) m_mode = M_RUN;
      endcase
    end
    cyc++;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] hi_exp [3];
    bit          found;
    bit          hlt_st;
    hi_exp[0] = 32'hFFFF_FFF8; hi_exp[1] = 32'hFFFF_FFFC; hi_exp[2] = 32'h0000_0000;

    reset = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    halt = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

    // reset held
    repeat (3) cycle(0, 1, 0, 32'h0, 0, 100, 100);
    chk("lit_rst_addr_hi", hi_addr, 32'hFFFF_FFF8);
    chk("lit_rst_req",     32'(imem_req), 32'd0);

    // streaming after release: addresses 0,4,8.. ; inst_pc trails by 2
    cycle(1, 1, 0, 32'h0, 0, 100, 100);
    chk("lit_boot_no_req", 32'(imem_req), 32'd0);
    for (int j = 1; j <= 6; j++) begin
      cycle(1, 1, 0, 32'h0, 0, 100, 100);
      chk("lit_stream_req",  32'(imem_req), 32'd1);
      chk("lit_stream_addr", imem_addr, 32'(4 * (j - 1)));
      if (j <= 3) chk("lit_wrap_addr", hi_addr, hi_exp[j-1]);
      if (j >= 3) begin
        chk("lit_stream_valid", 32'(inst_valid), 32'd1);
        chk("lit_stream_pc",    inst_pc, 32'(4 * (j - 3)));
      end
    end

    // ready low: buffer fills, no requests; one pop frees exactly one
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0, 0, 32'h0, 0, 100, 100);
      if (k >= 1) begin
        chk("lit_full_no_req", 32'(imem_req), 32'd0);
        chk("lit_full_valid",  32'(inst_valid), 32'd1);
      end
    end
    cycle(1, 1, 0, 32'h0, 0, 100, 100);
    chk("lit_pop_req",  32'(imem_req), 32'd1);
    chk("lit_pop_addr", imem_addr, 32'h18);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 0, 32'h0, 0, 100, 100);
      chk("lit_after_pop_no_req", 32'(imem_req), 32'd0);
    end

    // redirect with two requests outstanding (low target bits ignored)
    repeat (4) cycle(1, 1, 0, 32'h0, 0, 100, 0);
    cycle(1, 1, 1, 32'h0000_0103, 0, 100, 0);
    chk("lit_redir_no_req", 32'(imem_req), 32'd0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle(1, 1, 0, 32'h0, 0, 100, 100);
      if (inst_valid) found = 1'b1;
    end
    chk("lit_redir_seen", 32'(found), 32'd1);
    chk("lit_redir_pc0",  inst_pc, 32'h100);
    cycle(1, 1, 0, 32'h0, 0, 100, 100);
    chk("lit_redir_valid1", 32'(inst_valid), 32'd1);
    chk("lit_redir_pc1",    inst_pc, 32'h104);

    // redirect + rvalid + pop in one cycle
    repeat (3) cycle(1, 1, 0, 32'h0, 0, 100, 100);
    cycle(1, 1, 1, 32'h3000, 0, 100, 100);
    chk("lit_triple_valid", 32'(inst_valid), 32'd1);
    cycle(1, 1, 0, 32'h0, 0, 100, 100);
    chk("lit_triple_empty", 32'(inst_valid), 32'd0);
    chk("lit_triple_req",   32'(imem_req), 32'd1);
    chk("lit_triple_addr",  imem_addr, 32'h3000);

    // halt mid-stream, drain, resume at next sequential pc
    cycle(1, 1, 0, 32'h0, 0, 100, 100);
    chk("lit_pre_halt_addr", imem_addr, 32'h3004);
    cycle(1, 1, 0, 32'h0, 1, 100, 100);
    chk("lit_halt_last_req",  32'(imem_req), 32'd1);
    chk("lit_halt_last_addr", imem_addr, 32'h3008);
    cycle(1, 1, 0, 32'h0, 1, 100, 100);
    chk("lit_halt_no_req",   32'(imem_req), 32'd0);
    chk("lit_halt_inflight", 32'(halted), 32'd0);
    cycle(1, 1, 0, 32'h0, 1, 100, 100);
    chk("lit_halted",        32'(halted), 32'd1);
    cycle(1, 1, 0, 32'h0, 1, 100, 100);
    chk("lit_halt_drained",  32'(inst_valid), 32'd0);
    chk("lit_halted_hold",   32'(halted), 32'd1);
    cycle(1, 1, 0, 32'h0, 0, 100, 100);
    chk("lit_unhalt_no_req", 32'(imem_req), 32'd0);
    cycle(1, 1, 0, 32'h0, 0, 100, 100);
    chk("lit_resume_req",  32'(imem_req), 32'd1);
    chk("lit_resume_addr", imem_addr, 32'h300C);

    // randomized traffic, including a mid-run reset
    hlt_st = 1'b0;
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(39) == 0) hlt_st = ~hlt_st;
      cycle((k == 1200 || k == 1201) ? 1'b0 : 1'b1,
            ($urandom_range(3) != 0),
            ($urandom_range(19) == 0),
            $urandom,
            hlt_st,
            (k < 1250) ? 70 : 40,
            (k < 1250) ? 60 : 85);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
